// File: rtl/imem_fetch_pkg.sv
// Shared constants for the instruction fetch block: FSM state encoding and
// the default instruction-memory placement.
package imem_fetch_pkg;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_3000;
  localparam int          DEF_ADDR_W    = 10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

endpackage

// File: rtl/fetch_addr_chk.sv
// Combinational pc check: flags misaligned or out-of-window addresses and
// converts a legal byte address into an instruction-memory word address.
module fetch_addr_chk
  import imem_fetch_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          ADDR_W    = DEF_ADDR_W
) (
  input  logic [31:0]       pc,
  output logic              legal,
  output logic [ADDR_W-1:0] word_addr
);

  logic [29:0] offset_w;
  logic        below_base;
  logic        above_top;
  logic        misaligned;

  // Work in word units so the low two pc bits only matter for alignment.
  assign offset_w   = pc[31:2] - BASE_ADDR[31:2];
  assign below_base = (pc[31:2] < BASE_ADDR[31:2]);
  assign above_top  = |offset_w[29:ADDR_W];
  assign misaligned = |pc[1:0];

  assign legal     = !misaligned && !below_base && !above_top;
  assign word_addr = offset_w[ADDR_W-1:0];

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch: accepts a pc, issues a single outstanding memory read,
// and holds the fetched word for decode; handles flush and sticky faults.
module imem_fetch
  import imem_fetch_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       imout,
  output logic [31:0]       imout_pc,
  output logic              imout_valid,
  input  logic              imout_ready,
  output logic              fault
);

  logic [2:0]        state_q, state_d;
  logic [31:0]       pc_lat_q, pc_lat_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       imout_q, imout_d;
  logic [31:0]       imout_pc_q, imout_pc_d;

  logic              pc_legal;
  logic [ADDR_W-1:0] pc_word;
  logic              accept;

  fetch_addr_chk #(
    .BASE_ADDR (BASE_ADDR),
    .ADDR_W    (ADDR_W)
  ) u_addr_chk (
    .pc        (pc),
    .legal     (pc_legal),
    .word_addr (pc_word)
  );

  assign pc_ready = !flush &&
                    ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && imout_ready));
  assign accept   = pc_valid && pc_ready;

  always_comb begin
    state_d    = state_q;
    pc_lat_d   = pc_lat_q;
    mem_addr_d = mem_addr_q;
    imout_d    = imout_q;
    imout_pc_d = imout_pc_q;

    case (state_q)
      ST_IDLE: ;
      ST_REQ: begin
        if (mem_ack) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            imout_d    = mem_rdata;
            imout_pc_d = pc_lat_q;
            state_d    = ST_HOLD;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem_ack) state_d = ST_IDLE;
      end
      ST_HOLD: begin
        if (flush || imout_ready) state_d = ST_IDLE;
      end
      ST_FAULT: ;
      default: state_d = ST_IDLE;
    endcase

    // An accept (IDLE, or HOLD being drained) overrides the plain transition above.
    if (accept) begin
      if (pc_legal) begin
        state_d    = ST_REQ;
        pc_lat_d   = pc;
        mem_addr_d = pc_word;
      end else begin
        state_d = ST_FAULT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pc_lat_q   <= '0;
      mem_addr_q <= '0;
      imout_q    <= '0;
      imout_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_lat_q   <= pc_lat_d;
      mem_addr_q <= mem_addr_d;
      imout_q    <= imout_d;
      imout_pc_q <= imout_pc_d;
    end
  end

  assign mem_req     = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign mem_addr    = mem_addr_q;
  assign imout       = imout_q;
  assign imout_pc    = imout_pc_q;
  assign imout_valid = (state_q == ST_HOLD);
  assign fault       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_imem_fetch.sv
// Self-checking bench for imem_fetch: directed corner cases plus randomized
// single fetches checked against a transaction-level legality/latency model.
module tb_imem_fetch;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          WORDS = 1024;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] imout;
  logic [31:0] imout_pc;
  logic        imout_valid;
  logic        imout_ready;
  logic        fault;

  int testsRun;
  int testsFailed;

  imem_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .imout       (imout),
    .imout_pc    (imout_pc),
    .imout_valid (imout_valid),
    .imout_ready (imout_ready),
    .fault       (fault)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference legality: word aligned and inside the 1K-word window.
  function automatic bit modelLegal(input logic [31:0] p);
    longint lp;
    lp = longint'(p);
    return (p[1:0] == 2'b00) && (lp >= longint'(BASE)) && (lp < longint'(BASE) + 4 * WORDS);
  endfunction

  task automatic doReset();
    rst = 1'b0; pc_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0; imout_ready = 1'b0;
    tick();
    #1;
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_imout", imout, 0);
    checkOutput("rst_imout_pc", imout_pc, 0);
    checkOutput("rst_imout_valid", imout_valid, 0);
    checkOutput("rst_fault", fault, 0);
    rst = 1'b1;
  endtask

  // One complete fetch from IDLE: accept, wait ackDelay cycles, optional
  // flush in the first request cycle, then stall decode for `stall` cycles.
  task automatic applyStimulus(input logic [31:0] p, input logic [31:0] data,
                               input int ackDelay, input int stall, input bit flushAtReq);
    bit          legal;
    logic [31:0] expAddr;
    legal   = modelLegal(p);
    expAddr = legal ? (p - BASE) >> 2 : 32'h0;
    pc = p; pc_valid = 1'b1; flush = 1'b0; imout_ready = 1'b0; mem_ack = 1'b0;
    #1;
    checkOutput("pc_ready_idle", pc_ready, 1);
    tick();
    pc_valid = 1'b0; pc = $urandom;
    #1;
    if (!legal) begin
      checkOutput("fault_set", fault, 1);
      checkOutput("fault_no_req", mem_req, 0);
      pc = BASE; pc_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        #1;
        checkOutput("fault_pc_ready", pc_ready, 0);
        tick();
        #1;
        checkOutput("fault_sticky", fault, 1);
        checkOutput("fault_req_idle", mem_req, 0);
        checkOutput("fault_no_valid", imout_valid, 0);
      end
      doReset();
      return;
    end
    for (int d = 0; d <= ackDelay; d++) begin
      flush     = flushAtReq && (d == 0);
      mem_ack   = (d == ackDelay);
      mem_rdata = mem_ack ? data : $urandom;
      #1;
      checkOutput("mem_req_held", mem_req, 1);
      checkOutput("mem_addr", mem_addr, expAddr);
      checkOutput("req_no_valid", imout_valid, 0);
      checkOutput("req_pc_ready", pc_ready, 0);
      tick();
    end
    flush = 1'b0; mem_ack = 1'b0;
    #1;
    if (flushAtReq) begin
      checkOutput("drop_valid", imout_valid, 0);
      checkOutput("drop_req", mem_req, 0);
      checkOutput("drop_pc_ready", pc_ready, 1);
      return;
    end
    for (int s = 0; s <= stall; s++) begin
      imout_ready = (s == stall);
      #1;
      checkOutput("hold_valid", imout_valid, 1);
      checkOutput("hold_imout", imout, data);
      checkOutput("hold_imout_pc", imout_pc, p);
      checkOutput("hold_pc_ready", pc_ready, (s == stall) ? 32'd1 : 32'd0);
      tick();
    end
    imout_ready = 1'b0;
    #1;
    checkOutput("post_hold_valid", imout_valid, 0);
    checkOutput("post_hold_req", mem_req, 0);
  endtask

  initial begin
    logic [31:0] rpc;
    testsRun = 0; testsFailed = 0;
    rst = 1'b0; pc = '0; pc_valid = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; imout_ready = 1'b0;
    tick();
    doReset();
    tick();

    // Zero-wait fetch of word 0, then the window edges.
    applyStimulus(32'h0000_3000, 32'h2008_0005, 0, 0, 1'b0);
    applyStimulus(32'h0000_3FFC, 32'h1234_5678, 0, 1, 1'b0);
    applyStimulus(32'h0000_3010, 32'hDEAD_BEEF, 3, 0, 1'b1);
    applyStimulus(32'h0000_3002, 32'h0, 0, 0, 1'b0);
    applyStimulus(32'h0000_2FFC, 32'h0, 0, 0, 1'b0);
    applyStimulus(32'h0000_4000, 32'h0, 0, 0, 1'b0);

    // Back-to-back: second pc accepted in the HOLD cycle goes straight to REQ.
    pc = 32'h3004; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001;
    tick();
    mem_ack = 1'b0; imout_ready = 1'b1; pc = 32'h3008; pc_valid = 1'b1;
    #1;
    checkOutput("b2b_first_imout", imout, 32'hAAAA_0001);
    checkOutput("b2b_pc_ready", pc_ready, 1);
    tick();
    pc_valid = 1'b0; imout_ready = 1'b0;
    #1;
    checkOutput("b2b_second_req", mem_req, 1);
    checkOutput("b2b_second_addr", mem_addr, 2);
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_0002;
    tick();
    mem_ack = 1'b0;
    #1;
    checkOutput("b2b_second_imout", imout, 32'hAAAA_0002);
    checkOutput("b2b_second_pc", imout_pc, 32'h3008);

    // Stall in HOLD for 4 cycles, then flush (beats imout_ready).
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("stall_imout", imout, 32'hAAAA_0002);
      checkOutput("stall_valid", imout_valid, 1);
    end
    flush = 1'b1; imout_ready = 1'b1; pc_valid = 1'b1; pc = 32'h3020;
    #1;
    checkOutput("flush_hold_pc_ready", pc_ready, 0);
    tick();
    flush = 1'b0; imout_ready = 1'b0; pc_valid = 1'b0;
    #1;
    checkOutput("flush_hold_valid", imout_valid, 0);
    checkOutput("flush_hold_idle", pc_ready, 1);

    // Flush in IDLE blocks acceptance for that cycle.
    flush = 1'b1; pc_valid = 1'b1; pc = 32'h3040;
    #1;
    checkOutput("flush_idle_pc_ready", pc_ready, 0);
    tick();
    flush = 1'b0; pc_valid = 1'b0;
    #1;
    checkOutput("flush_idle_no_req", mem_req, 0);

    // Reset mid-request, then a late ack that must be ignored.
    pc = 32'h3100; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    #1;
    checkOutput("midreq_req", mem_req, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    #1;
    checkOutput("midreq_abandon", mem_req, 0);
    tick();
    mem_ack = 1'b0;
    #1;
    checkOutput("late_ack_valid", imout_valid, 0);
    checkOutput("late_ack_idle", pc_ready, 1);

    // Randomized fetches with idle gaps carrying spurious acks.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0:       rpc = BASE + 32'($urandom_range(0, WORDS - 1)) * 4 + 32'($urandom_range(1, 3));
        1:       rpc = BASE - 32'($urandom_range(1, 64)) * 4;
        2:       rpc = BASE + 4 * WORDS + 32'($urandom_range(0, 64)) * 4;
        3:       rpc = $urandom;
        default: rpc = BASE + 32'($urandom_range(0, WORDS - 1)) * 4;
      endcase
      applyStimulus(rpc, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 4) == 0));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        mem_ack = $urandom_range(0, 1); mem_rdata = $urandom;
        tick();
        mem_ack = 1'b0;
        #1;
        checkOutput("gap_no_req", mem_req, 0);
        checkOutput("gap_no_valid", imout_valid, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_3000, byte address of instruction-memory word 0.
REQ-002 Parameter ADDR_W, default 10, word-address width of instruction memory (1K words).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 pc  input  32  byte address from next-PC logic.
REQ-006 pc_valid  input  1  pc is presented.
REQ-007 pc_ready  output  1  block accepts pc this cycle.
REQ-008 flush  input  1  redirect (taken beq, j, jal or jr); discard fetch in flight.
REQ-009 mem_req  output  1  read request to instruction memory.
REQ-010 mem_addr  output  ADDR_W  word address, equal to (pc-BASE_ADDR)>>2.
REQ-011 mem_ack  input  1  mem_rdata valid this cycle; completes the request.
REQ-012 mem_rdata  input  32  instruction word from memory.
REQ-013 imout  output  32  fetched instruction.
REQ-014 imout_pc  output  32  byte address of imout.
REQ-015 imout_valid  output  1  imout and imout_pc valid.
REQ-016 imout_ready  input  1  decode stage consumes imout.
REQ-017 fault  output  1  misaligned or out-of-range pc; sticky.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, REQ, DRAIN, HOLD and FAULT.
REQ-019 pc_ready SHALL be 1 in IDLE, and in HOLD when imout_ready=1; it SHALL be 0 otherwise and whenever flush=1.
REQ-020 On accept (pc_valid & pc_ready), a pc with pc[1:0]!=0, pc<BASE_ADDR or pc>=BASE_ADDR+4*2^ADDR_W SHALL move the FSM to FAULT and issue no request.
REQ-021 On accept of a legal pc, the block SHALL latch pc and mem_addr and enter REQ.
REQ-022 REQ: mem_req=1, with mem_addr held stable, until the cycle of mem_ack.
REQ-023 On mem_ack in REQ, imout<=mem_rdata and imout_pc<=latched pc, then HOLD; minimum latency is accept at cycle N, mem_req at N+1, imout_valid at N+2.
REQ-024 HOLD: imout_valid=1, and imout and imout_pc stay stable until imout_ready=1.
REQ-025 HOLD with imout_ready=1 and a legal pc accepted in the same cycle SHALL go directly to REQ, with no IDLE bubble.
REQ-026 HOLD with imout_ready=1 and no accept SHALL go to IDLE.
REQ-027 flush in IDLE: the block SHALL ignore pc_valid for that cycle.
REQ-028 flush in REQ without mem_ack: go to DRAIN; mem_req SHALL stay 1 until mem_ack, because a request is never retracted.
REQ-029 flush in REQ with mem_ack in the same cycle: drop the data and go to IDLE.
REQ-030 DRAIN: on mem_ack, drop the data and go to IDLE; imout_valid stays 0.
REQ-031 flush in HOLD: imout_valid<=0 next cycle and the FSM goes to IDLE; flush has priority over imout_ready.
REQ-032 FAULT: fault=1, imout_valid=0, pc_ready=0, mem_req=0; the FSM leaves FAULT only on reset.
REQ-033 At most one request SHALL be outstanding.
REQ-034 mem_ack outside REQ and DRAIN SHALL be ignored.

Reset
REQ-035 With rst=0 at a clock edge: state<=IDLE, mem_req=0, mem_addr=0, imout=0, imout_pc=0, imout_valid=0, fault=0.
REQ-036 Reset asserted mid-request SHALL abandon the request; the memory model SHALL tolerate a late ack, which REQ-034 ignores.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding, the BASE_ADDR default (32'h0000_3000) and the ADDR_W default.
REQ-038 Sub-module fetch_addr_chk (combinational) SHALL produce the legal flag and the word address from pc; all other logic SHALL live in imem_fetch.

Verification
REQ-039 Reset, then pc=32'h0000_3000 with zero-wait ack and rdata=32'h2008_0005 -> imout_valid at N+2, imout=32'h2008_0005, imout_pc=32'h0000_3000, mem_addr=0.
REQ-040 Back-to-back pc 32'h3004 and 32'h3008 with imout_ready held 1 -> second mem_req in the cycle after the first HOLD; no IDLE bubble.
REQ-041 pc=32'h3010, ack delayed 3 cycles, flush at the first REQ cycle -> mem_req held until ack, imout_valid stays 0, then pc_ready=1.
REQ-042 pc=32'h3002 -> fault=1 next cycle, no mem_req; fault persists until rst=0.
REQ-043 pc=32'h2FFC and pc=32'h4000 (ADDR_W=10) -> fault=1; pc=32'h3FFC -> legal, mem_addr=10'h3FF.
REQ-044 HOLD with imout_ready=0 for 4 cycles, then flush -> imout stable for 4 cycles, then imout_valid=0 and the FSM returns to IDLE.
